cnn_kernel_bias_loader: RTL
===========================

Name: cnn_kernel_bias_loader

Overview:
- Sequences PS-side loading of the kernel/bias BRAM bank array (KERNEL_BRAM_NUM banks, port A).
- Accepts a valid/ready word stream and clears the banks first via their port-A resets.
- Distributes words round-robin across banks and signals completion to the layer controller.
- Sits between the PS data mover and the kernel/bias memory wrapper; port B (CNN read side) is untouched.

Parameters:
DATA_WIDTH, 32, BRAM word width
KERNEL_BRAM_NUM, 4, number of kernel/bias banks
KERNEL_BIAS_BRAM_ADDRESS_WIDTH, 4, per-bank port-A address width
KERNEL_BIAS_WIDTH, 8, width of word-count input
CLEAR_CYCLES, 2, cycles the bank resets are held (>=1)

Ports:
i_clock  in  1  sole clock
i_reset  in  1  synchronous, active-low reset
i_start  in  1  one-cycle load request (sampled in IDLE only)
i_word_count  in  KERNEL_BIAS_WIDTH  total words to load
i_data_valid  in  1  stream word valid
i_data  in  DATA_WIDTH  stream word
o_data_ready  out  1  stream ready
o_ps_enable  out  [0:0] x KERNEL_BRAM_NUM (unpacked)  port-A enable per bank
o_wenable  out  [0:0] x KERNEL_BRAM_NUM (unpacked)  port-A write enable per bank
o_waddress  out  KERNEL_BIAS_BRAM_ADDRESS_WIDTH x KERNEL_BRAM_NUM (unpacked)  port-A address per bank
o_bram_data  out  DATA_WIDTH x KERNEL_BRAM_NUM (unpacked)  port-A write data per bank
o_kernel_bias_bram_rst  out  KERNEL_BRAM_NUM  port-A reset per bank
o_busy  out  1  high from accepted start until done
o_done  out  1  one-cycle completion pulse
o_error  out  1  sticky overflow flag, cleared on next accepted start
o_checksum  out  DATA_WIDTH  see Optional Feature

Behaviour:
- Reset: i_reset is synchronous active-low, single clock i_clock. While i_reset==0, all outputs are 0 and state is IDLE. Reset mid-load abandons the load; bank contents are undefined; no reset pulse is issued to the banks.
- State machine: IDLE -> CLEAR -> LOAD -> DONE -> IDLE.
- IDLE:
  - i_start==1: capture i_word_count as N, clear o_error, set o_busy.
  - If N > KERNEL_BRAM_NUM*2^KERNEL_BIAS_BRAM_ADDRESS_WIDTH: set o_error, go to DONE (no clear, no writes).
  - Otherwise go to CLEAR.
- CLEAR: o_kernel_bias_bram_rst = all ones for exactly CLEAR_CYCLES cycles. Then go to LOAD, or to DONE if N==0.
- LOAD:
  - o_data_ready=1. A word transfers when valid&&ready.
  - Word k (0-based) goes to bank b=k mod KERNEL_BRAM_NUM, address a=k div KERNEL_BRAM_NUM.
  - Writes are registered: a transfer in cycle t gives o_ps_enable[b]=o_wenable[b]=1, o_waddress[b]=a, o_bram_data[b]=word in cycle t+1. All other banks have enable/wenable 0 that cycle.
  - Bank index wraps to 0 after KERNEL_BRAM_NUM-1 and the address then increments.
  - o_data_ready drops in the cycle after the N-th transfer, then go to DONE. Back-to-back transfers are sustained at 1 word/cycle.
- DONE: o_done=1 for one cycle (also in the overflow case), o_busy=0, return to IDLE.
- i_start in any state other than IDLE is ignored.
- o_waddress/o_bram_data hold their last value when not written; o_ps_enable=0 outside writes.

Optional Feature:
- Macro CNN_LOADER_CHECKSUM_EN.
- Defined: o_checksum = running XOR of all accepted words. It clears on accepted start, is updated in the same cycle as each write, and is stable from o_done onward.
- Undefined: o_checksum is tied to 0 and no checksum logic is built.

Decomposition:
- Package cnn_loader_pkg holds:
  - loader_state_e enum (IDLE, CLEAR, LOAD, DONE)
  - CLEAR_CYCLES default constant
  - capacity function (KERNEL_BRAM_NUM << address width)
- One sub-module, cnn_bank_addr_counter: bank index and per-bank address counter with wrap; inputs clear/advance; outputs bank, addr, count.

Test Plan:
- Reset during LOAD after 3 words -> next cycle all outputs 0, state IDLE; a new start with N=4 completes normally.
- Start N=6, valid held high -> rst all ones for 2 cycles; then writes land at bank0@0, bank1@0, bank2@0, bank3@0, bank0@1, bank1@1 on consecutive cycles; o_done pulses 1 cycle after the last write; o_busy falls with it.
- Start N=5 with valid toggling 1,0,1,0 -> writes occur only in cycles after a transfer; exactly 5 writes; ready low after the 5th transfer.
- Start N=0 -> 2-cycle clear, no writes, o_done pulse, o_error=0.
- Start N=65 (capacity 64) -> o_error=1, no rst pulse, no writes, o_done pulse. A following start N=1 clears o_error.
- With CNN_LOADER_CHECKSUM_EN, N=4 words 0x1,0x2,0x4,0x8 -> o_checksum=0xF at o_done. Without the macro -> o_checksum=0.

Source files
------------

// File: rtl/cnn_loader_pkg.sv
// Shared types and constants for the kernel/bias BRAM loader.
package cnn_loader_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} loader_state_e;

  localparam int CLEAR_CYCLES_DEF = 2;

  // Total port-A words across the whole bank array.
  function automatic int unsigned capacity(input int unsigned banks, input int unsigned aw);
    return banks << aw;
  endfunction

endpackage

// File: rtl/cnn_bank_addr_counter.sv
// Round-robin bank index with per-bank address; bank wraps first, then address advances.
module cnn_bank_addr_counter #(
  parameter int BANKS = 4,
  parameter int AW    = 4,
  parameter int CW    = 8,
  parameter int BW    = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_clear,
  input  logic          i_advance,
  output logic [BW-1:0] o_bank,
  output logic [AW-1:0] o_addr,
  output logic [CW-1:0] o_count
);

  logic [BW-1:0] bank_q;
  logic [AW-1:0] addr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge i_clock) begin
    if (!i_reset || i_clear) begin
      bank_q  <= '0;
      addr_q  <= '0;
      count_q <= '0;
    end else if (i_advance) begin
      count_q <= count_q + CW'(1);
      if (bank_q == BW'(BANKS - 1)) begin
        bank_q <= '0;
        addr_q <= addr_q + AW'(1);
      end else begin
        bank_q <= bank_q + BW'(1);
      end
    end
  end

  assign o_bank  = bank_q;
  assign o_addr  = addr_q;
  assign o_count = count_q;

endmodule

// File: rtl/cnn_kernel_bias_loader.sv
// PS-side loader for the kernel/bias BRAM array: clear banks, then stream words round-robin.
// Optional running-XOR checksum enabled by CNN_LOADER_CHECKSUM_EN.
module cnn_kernel_bias_loader
  import cnn_loader_pkg::*;
#(
  parameter int DATA_WIDTH                     = 32,
  parameter int KERNEL_BRAM_NUM                = 4,
  parameter int KERNEL_BIAS_BRAM_ADDRESS_WIDTH = 4,
  parameter int KERNEL_BIAS_WIDTH              = 8,
  parameter int CLEAR_CYCLES                   = CLEAR_CYCLES_DEF
) (
  input  logic                                      i_clock,
  input  logic                                      i_reset,
  input  logic                                      i_start,
  input  logic [KERNEL_BIAS_WIDTH-1:0]              i_word_count,
  input  logic                                      i_data_valid,
  input  logic [DATA_WIDTH-1:0]                     i_data,
  output logic                                      o_data_ready,
  output logic [0:0]                                o_ps_enable [KERNEL_BRAM_NUM],
  output logic [0:0]                                o_wenable [KERNEL_BRAM_NUM],
  output logic [KERNEL_BIAS_BRAM_ADDRESS_WIDTH-1:0] o_waddress [KERNEL_BRAM_NUM],
  output logic [DATA_WIDTH-1:0]                     o_bram_data [KERNEL_BRAM_NUM],
  output logic [KERNEL_BRAM_NUM-1:0]                o_kernel_bias_bram_rst,
  output logic                                      o_busy,
  output logic                                      o_done,
  output logic                                      o_error,
  output logic [DATA_WIDTH-1:0]                     o_checksum
);

  localparam int          AW  = KERNEL_BIAS_BRAM_ADDRESS_WIDTH;
  localparam int          KBW = KERNEL_BIAS_WIDTH;
  localparam int          BW  = (KERNEL_BRAM_NUM > 1) ? $clog2(KERNEL_BRAM_NUM) : 1;
  localparam int          CCW = $clog2(CLEAR_CYCLES + 1);
  localparam int unsigned CAP = capacity(KERNEL_BRAM_NUM, AW);

  loader_state_e  state_q;
  logic [KBW-1:0] n_q;
  logic [CCW-1:0] clr_cnt_q;
  logic           rst_q, ready_q, busy_q, done_q, err_q;

  logic [BW-1:0]  bank;
  logic [AW-1:0]  addr;
  logic [KBW-1:0] count;
  logic           start_acc, overflow, xfer, last_xfer;

  assign start_acc = (state_q == IDLE) && i_start;
  assign overflow  = 32'(i_word_count) > CAP;
  assign xfer      = ready_q && i_data_valid;
  assign last_xfer = xfer && (count == n_q - KBW'(1));

  cnn_bank_addr_counter #(
    .BANKS(KERNEL_BRAM_NUM), .AW(AW), .CW(KBW), .BW(BW)
  ) u_cnt (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (start_acc),
    .i_advance(xfer),
    .o_bank   (bank),
    .o_addr   (addr),
    .o_count  (count)
  );

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q   <= IDLE;
      n_q       <= '0;
      clr_cnt_q <= '0;
      rst_q     <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (i_start) begin
          n_q       <= i_word_count;
          err_q     <= 1'b0;
          busy_q    <= 1'b1;
          clr_cnt_q <= '0;
          if (overflow) begin
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            rst_q   <= 1'b1;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + CCW'(1);
          if (clr_cnt_q == CCW'(CLEAR_CYCLES - 1)) begin
            rst_q <= 1'b0;
            if (n_q == '0) begin
              state_q <= DONE;
            end else begin
              ready_q <= 1'b1;
              state_q <= LOAD;
            end
          end
        end
        LOAD: if (last_xfer) begin
          ready_q <= 1'b0;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Port-A write registers: one bank strobed per transfer, address/data hold otherwise.
  for (genvar b = 0; b < KERNEL_BRAM_NUM; b++) begin : g_bank
    logic            wen_q;
    logic [AW-1:0]   waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic            hit;

    assign hit = xfer && (bank == BW'(b));

    always_ff @(posedge i_clock) begin
      if (!i_reset) begin
        wen_q   <= 1'b0;
        waddr_q <= '0;
        wdata_q <= '0;
      end else begin
        wen_q <= hit;
        if (hit) begin
          waddr_q <= addr;
          wdata_q <= i_data;
        end
      end
    end

    assign o_ps_enable[b] = wen_q;
    assign o_wenable[b]   = wen_q;
    assign o_waddress[b]  = waddr_q;
    assign o_bram_data[b] = wdata_q;
  end

`ifdef CNN_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] cksum_q, cksum_d;

  assign cksum_d = start_acc ? '0 : (xfer ? (cksum_q ^ i_data) : cksum_q);

  always_ff @(posedge i_clock) begin
    if (!i_reset) cksum_q <= '0;
    else          cksum_q <= cksum_d;
  end

  assign o_checksum = cksum_q;
`else
  assign o_checksum = '0;
`endif

  assign o_data_ready           = ready_q;
  assign o_kernel_bias_bram_rst = {KERNEL_BRAM_NUM{rst_q}};
  assign o_busy                 = busy_q;
  assign o_done                 = done_q;
  assign o_error                = err_q;

endmodule
